// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries between fetch and decode.
// Flush wins over push and pop; a push is accepted when full only if a pop
// frees the head in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_en;
    logic            pop_en;
    logic            write_en;

    fetch_entry_t mem_q [DEPTH];

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CntW'(DEPTH));
    assign pop_en   = pop_i && !empty_o;
    assign push_en  = push_i && (!full_o || pop_en);
    assign write_en = push_en && !flush_i;

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero, so no reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Occupancy never exceeds the buffer size.
    assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection, RUN/FLUSH FSM
// and the fetch buffer presenting instructions to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_state_t    state_q, state_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t       fifo_head;
    fetch_entry_t       fifo_wdata;

    // The memory address is the PC register itself: no input reaches it combinationally.
    assign imem_addr = pc_q;

    // Head is hidden during FLUSH; the buffer is empty then anyway after the flush.
    assign out_valid = !fifo_empty && (state_q == RUN);
    assign fifo_pop  = out_valid && out_ready;

    // Fetch only when not redirecting and there is room (or room is being made).
    assign fifo_push = !redirect_valid && (!fifo_full || fifo_pop);

    assign fifo_wdata.pc    = pc_q;
    assign fifo_wdata.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Next PC and FSM state; redirect outranks sequential fetch.
    always_comb begin
        pc_d    = pc_q;
        state_d = RUN;
        if (redirect_valid) begin
            pc_d    = word_align(redirect_pc);
            state_d = FLUSH;
        end else if (fifo_push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // Head-to-output mux: NOP and PC 0 when nothing valid is presented.
    always_comb begin
        out_instr = INSTR_NOP;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = fifo_head.instr;
            out_pc    = fifo_head.pc;
        end
        out_pc_plus4 = out_pc + 32'd4;
    end

    // A redirect always leaves the buffer empty for the FLUSH cycle.
    assert property (@(posedge clk) disable iff (!rst_n) (state_q == FLUSH) |-> (fifo_count == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a queue-based reference model and
// directed literal checks for the reset, backpressure, redirect and wrap cases.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int vectors     = 0;
    int miscompares = 0;

    // Instruction memory: 64 words, aliased over the address space.
    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {pc, instr}, a PC and a "just redirected" flag.
    logic [63:0] m_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_flush = 1'b0;

    initial begin
        bit vld;
        bit pop;
        bit space;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_pc    = RESET_PC;
                m_flush = 1'b0;
            end else begin
                vld = !m_flush && (m_q.size() > 0);
                pop = vld && out_ready;
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc    = redirect_pc & 32'hFFFF_FFFC;
                    m_flush = 1'b1;
                end else begin
                    space = (m_q.size() < DEPTH) || pop;
                    if (pop) void'(m_q.pop_front());
                    if (space) begin
                        m_q.push_back({m_pc, mem[m_pc[7:2]]});
                        m_pc = m_pc + 32'd4;
                    end
                    m_flush = 1'b0;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        forever begin
            @(negedge clk);
            e_valid = !m_flush && (m_q.size() > 0);
            e_instr = e_valid ? m_q[0][31:0]  : NOP;
            e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
            check("model.out_valid", {31'b0, out_valid}, {31'b0, e_valid});
            check("model.out_instr", out_instr, e_instr);
            check("model.out_pc", out_pc, e_pc);
            check("model.out_pc_plus4", out_pc_plus4, e_pc + 32'd4);
            check("model.imem_addr", imem_addr, m_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        tick();
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.out_instr", out_instr, NOP);
        check("rst.out_pc", out_pc, 32'h0);
        check("rst.imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream
        tick();
        check("s1.out_instr", out_instr, 32'h0050_0113);
        check("s1.out_pc", out_pc, 32'h0);
        check("s1.out_pc_plus4", out_pc_plus4, 32'h4);
        tick();
        check("s2.out_instr", out_instr, 32'h00C0_0193);
        check("s2.out_pc", out_pc, 32'h4);

        // Backpressure from reset
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        check("bp.imem_addr", imem_addr, 32'h8);
        check("bp.out_instr", out_instr, 32'h0050_0113);
        check("bp.out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp.rel1.out_pc", out_pc, 32'h4);
        tick();
        check("bp.rel2.out_pc", out_pc, 32'h8);

        // Single redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        tick();
        redirect_valid = 1'b0;
        check("rd.out_valid", {31'b0, out_valid}, 32'd0);
        check("rd.imem_addr", imem_addr, 32'h40);
        tick();
        check("rd.out_pc", out_pc, 32'h40);

        // Back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        check("b2b.out_valid", {31'b0, out_valid}, 32'd0);
        check("b2b.imem_addr", imem_addr, 32'h20);
        tick();
        check("b2b.out_pc", out_pc, 32'h20);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap.imem_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap.out_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap.out_pc_plus4", out_pc_plus4, 32'h0);
        check("wrap.imem_addr1", imem_addr, 32'h0);

        // Async reset between edges with a full buffer
        out_ready = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid", {31'b0, out_valid}, 32'd0);
        check("ar.imem_addr", imem_addr, RESET_PC);
        check("ar.out_instr", out_instr, NOP);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar.restart_pc", out_pc, RESET_PC);
        check("ar.restart_instr", out_instr, 32'h0050_0113);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(9) < 7);
            redirect_valid = ($urandom_range(9) == 0);
            redirect_pc    = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
